// File: rtl/ats21_alarm_event_queue.sv
// ATS21 alarm event queue: turns rising edges on the alarm level bus into
// timestamped {id, ts} entries held in a show-ahead FIFO for the host.
module ats21_alarm_event_queue #(
   parameter int NUM_ALARMS = 24,
   parameter int ID_WIDTH   = 5,
   parameter int DEPTH      = 8,
   parameter int TS_WIDTH   = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_ALARMS-1:0]      alarm_data,
   input  logic                       evt_pop,
   input  logic                       clr_overflow,
   output logic                       evt_valid,
   output logic [ID_WIDTH-1:0]        evt_id,
   output logic [TS_WIDTH-1:0]        evt_ts,
   output logic [NUM_ALARMS-1:0]      pending,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   output logic                       irq
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [NUM_ALARMS-1:0] r_prev;
   logic [NUM_ALARMS-1:0] r_pending;
   logic [TS_WIDTH-1:0]   r_ts;
   logic [ID_WIDTH-1:0]   r_mem_id [DEPTH];
   logic [TS_WIDTH-1:0]   r_mem_ts [DEPTH];
   logic [PW-1:0]         r_wptr;
   logic [PW-1:0]         r_rptr;
   logic [CW-1:0]         r_count;
   logic                  r_overflow;

   logic [NUM_ALARMS-1:0] w_rise;
   logic [NUM_ALARMS-1:0] w_enq_mask;
   logic [NUM_ALARMS-1:0] w_pending_nxt;
   logic [ID_WIDTH-1:0]   w_enq_idx;
   logic                  w_space;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_lost;

   // Lowest set pending bit wins the single enqueue slot of this cycle
   always_comb begin
      w_enq_idx = '0;
      for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
         if (r_pending[i]) begin
            w_enq_idx = ID_WIDTH'(i);
         end else begin
            w_enq_idx = w_enq_idx;
         end
      end
   end

   // Space includes the full-with-pop case, where the head slot is freed this edge
   always_comb begin
      w_rise        = alarm_data & ~r_prev;
      w_space       = (r_count < DEPTH_C) || ((r_count == DEPTH_C) && evt_pop);
      w_push        = (|r_pending) && w_space;
      w_pop         = evt_pop && (r_count != '0);
      if (w_push) begin
         w_enq_mask = NUM_ALARMS'(1) << w_enq_idx;
      end else begin
         w_enq_mask = '0;
      end
      w_lost        = |(w_rise & r_pending & ~w_enq_mask);
      w_pending_nxt = (r_pending & ~w_enq_mask) | w_rise;
   end

   // Edge history, pending capture, timestamp and sticky overflow
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_prev     <= '1;
         r_pending  <= '0;
         r_ts       <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_prev     <= alarm_data;
         r_pending  <= w_pending_nxt;
         r_ts       <= r_ts + TS_WIDTH'(1);
         if (w_lost) begin
            r_overflow <= 1'b1;
         end else if (clr_overflow) begin
            r_overflow <= 1'b0;
         end else begin
            r_overflow <= r_overflow;
         end
      end
   end

   // FIFO storage, pointers and occupancy
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < DEPTH; k++) begin
            r_mem_id[k] <= '0;
            r_mem_ts[k] <= '0;
         end
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_mem_id[r_wptr] <= w_enq_idx;
            r_mem_ts[r_wptr] <= r_ts;
            r_wptr           <= r_wptr + PW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign evt_valid = (r_count != '0);
   assign evt_id    = evt_valid ? r_mem_id[r_rptr] : '0;
   assign evt_ts    = evt_valid ? r_mem_ts[r_rptr] : '0;
   assign pending   = r_pending;
   assign count     = r_count;
   assign overflow  = r_overflow;
   assign irq       = evt_valid | r_overflow;

endmodule

// File: doc/ats21_alarm_event_queue.md
Name: ats21_alarm_event_queue

Overview:
- Downstream consumer of the ATS21 alarm/timer outputs. It watches the 24-bit alarm data bus and converts each alarm firing (a level held high for two cycles) into a single queued event.
- Each event holds the alarm index and a timestamp. Events sit in a FIFO until the host pops them.
- Raises an interrupt while events are waiting or an overflow has occurred. This gives the host a lossless, ordered record of alarm activity instead of transient level pulses.

Parameters:
- NUM_ALARMS, 24, number of alarm inputs (width of alarm_data and pending).
- ID_WIDTH, 5, alarm index width; must satisfy 2^ID_WIDTH >= NUM_ALARMS.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- TS_WIDTH, 16, timestamp counter width.

Ports:
- clk  in  1  single design clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- alarm_data  in  NUM_ALARMS  level outputs of ATS21; bit i is high while alarm i is finished.
- evt_pop  in  1  host consumes the head entry on this cycle's posedge.
- clr_overflow  in  1  clears the sticky overflow flag.
- evt_valid  out  1  FIFO is non-empty.
- evt_id  out  ID_WIDTH  alarm index of the head entry.
- evt_ts  out  TS_WIDTH  timestamp of the head entry.
- pending  out  NUM_ALARMS  edges captured but not yet enqueued.
- count  out  $clog2(DEPTH+1)  current FIFO occupancy.
- overflow  out  1  sticky: an event was lost.
- irq  out  1  equals evt_valid OR overflow.

Behaviour:

Reset (reset=0, asynchronous):
- Clears FIFO, pending, count, overflow, timestamp counter.
- All outputs go to 0.
- The previous-sample register prev is set to all ones, so any alarm_data bit already high at reset release is not an event.

Timestamp:
- Free-running TS_WIDTH counter, increments every cycle.
- Wraps from all ones to 0 with no flag.

Edge detect:
- rise = alarm_data & ~prev. prev <= alarm_data every cycle.

Capture:
- At posedge k, for each bit with rise[i]=1, pending[i] <= 1.
- If pending[i] is already 1 and is not being enqueued at posedge k, the event is dropped and overflow <= 1.

Enqueue:
- Each posedge, if pending is non-zero and there is space, the lowest set index j is written as {id=j, ts=counter value before increment}.
- pending[j] is cleared in the same cycle.
- At most one enqueue per cycle.
- Simultaneous edges drain in ascending index order on consecutive cycles.
- Space means count<DEPTH, or count==DEPTH with evt_pop=1 in the same cycle.

Latency:
- alarm_data[i] first sampled high at posedge k gives pending[i]=1 after posedge k.
- If it is the lowest pending bit and space exists, it is enqueued at posedge k+1: evt_valid=1 and evt_id=i after k+1, with evt_ts = counter value at k+1.

FIFO:
- Show-ahead: evt_id and evt_ts always reflect the head entry; both read 0 when empty.
- Pop when empty is ignored; count never underflows.
- Simultaneous push and pop leaves count unchanged.
- Full with no pop: pending bits hold; they are not lost. Loss happens only on a re-edge of a bit that is still pending.

Overflow:
- Sticky; cleared by clr_overflow.
- If a set condition and clr_overflow occur in the same cycle, set wins.

Pointers:
- Read and write pointers are $clog2(DEPTH) bits and wrap naturally.
- count is tracked separately so full and empty are unambiguous.

Alarm behaviour:
- A repeating alarm re-firing produces a new rising edge, which is a new event.
- Holding a level high for more than two cycles produces one event only.

Test Plan:
1. Reset release with alarm_data=0x000001 held high, then no change -> no event; evt_valid=0; irq=0.
2. alarm_data[5] high for 2 cycles starting at posedge 10 after reset -> pending[5]=1 after posedge 10; evt_valid=1, evt_id=5 after posedge 11; evt_ts=11; irq=1; pop -> count=0, irq=0.
3. alarm_data = 0x800101 rises in one cycle -> three entries in order id=0, 8, 23 with consecutive timestamps t, t+1, t+2; count=3.
4. DEPTH=8 with no pops; fire alarms 0..9 on separate cycles -> count=8; pending bits 8 and 9 held; overflow=0. Pop twice -> ids 8 and 9 enqueued; count=8.
5. FIFO full, pending[3]=1, new rising edge on bit 3 -> overflow=1 and irq=1 while the FIFO holds its entries. clr_overflow -> overflow=0. Set and clear asserted together -> overflow=1.
6. Timestamp wrap: run 65535 cycles, fire alarm 2 so it is enqueued at counter 0xFFFF and alarm 4 one cycle later -> evt_ts 0xFFFF then 0x0000. Assert reset mid-queue -> count=0, pending=0, evt_valid=0 immediately, without waiting for a clock edge.
